// File: rtl/k_select_sorter.sv
// Streaming top-k selector: keeps the k best (name, value) pairs in a sorted
// register array during LOAD, then drains them in rank order over valid/ready.
module k_select_sorter #(
    parameter int NAME_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int KW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KW-1:0]         k,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [NAME_WIDTH-1:0] in_name,
    input  logic [DATA_WIDTH-1:0] in_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NAME_WIDTH-1:0] out_name,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic                  out_last,
    output logic                  busy,
    output logic [KW-1:0]         count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [KW-1:0] DEPTH_K = KW'(DEPTH);
    localparam logic [KW-1:0] ONE_K   = KW'(1);
    localparam logic [KW-1:0] TWO_K   = KW'(2);

    state_t                  state_r;
    logic [KW-1:0]           kq_r;
    logic                    mode_r;
    logic [KW-1:0]           count_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    out_last_r;
    logic                    busy_r;
    logic [DATA_WIDTH-1:0]   val_r  [DEPTH];
    logic [NAME_WIDTH-1:0]   name_r [DEPTH];
    logic [DEPTH-1:0]        vld_r;

    logic [KW-1:0]           p_s;
    logic [KW-1:0]           kq_s;
    logic                    accept_s;
    logic                    pop_s;
    logic                    ins_ok_s;
    logic [KW-1:0]           count_ins_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign count     = count_r;
    assign out_name  = name_r[0];
    assign out_value = val_r[0];

    // Insert position: equal values already held rank ahead of the newcomer.
    always_comb begin
        p_s = {KW{1'b0}};
        for (int j = 0; j < DEPTH; j++) begin
            if (vld_r[j] && (KW'(j) < kq_r) &&
                (mode_r ? (val_r[j] >= in_value) : (val_r[j] <= in_value))) begin
                p_s = p_s + ONE_K;
            end else begin
                p_s = p_s;
            end
        end
    end

    // Handshake qualifiers, clamped k and post-insertion occupancy.
    always_comb begin
        accept_s = in_valid & in_ready_r;
        pop_s    = out_valid_r & out_ready;
        ins_ok_s = (p_s < kq_r);
        if (k == {KW{1'b0}}) begin
            kq_s = ONE_K;
        end else if (k > DEPTH_K) begin
            kq_s = DEPTH_K;
        end else begin
            kq_s = k;
        end
        if (ins_ok_s && (count_r < kq_r)) begin
            count_ins_s = count_r + ONE_K;
        end else begin
            count_ins_s = count_r;
        end
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            kq_r        <= {KW{1'b0}};
            mode_r      <= 1'b0;
            count_r     <= {KW{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_LOAD;
                        kq_r       <= kq_s;
                        mode_r     <= mode;
                        count_r    <= {KW{1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        count_r <= count_ins_s;
                        if (in_last) begin
                            state_r     <= ST_DRAIN;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_last_r  <= (count_ins_s == ONE_K);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop_s) begin
                        if (out_last_r) begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            count_r     <= {KW{1'b0}};
                        end else begin
                            count_r    <= count_r - ONE_K;
                            out_last_r <= (count_r == TWO_K);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    count_r     <= {KW{1'b0}};
                end
            endcase
        end
    end

    // Slot array: shift-down insert while loading, shift-up pop while draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= {DEPTH{1'b0}};
            for (int j = 0; j < DEPTH; j++) begin
                val_r[j]  <= {DATA_WIDTH{1'b0}};
                name_r[j] <= {NAME_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s && ins_ok_s) begin
                        for (int j = 1; j < DEPTH; j++) begin
                            if ((KW'(j) > p_s) && (KW'(j) < kq_r)) begin
                                val_r[j]  <= val_r[j-1];
                                name_r[j] <= name_r[j-1];
                                vld_r[j]  <= vld_r[j-1];
                            end
                        end
                        for (int j = 0; j < DEPTH; j++) begin
                            if (KW'(j) == p_s) begin
                                val_r[j]  <= in_value;
                                name_r[j] <= in_name;
                                vld_r[j]  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop_s) begin
                        if (out_last_r) begin
                            vld_r <= {DEPTH{1'b0}};
                        end else begin
                            for (int j = 0; j < DEPTH - 1; j++) begin
                                if (KW'(j + 1) < kq_r) begin
                                    val_r[j]  <= val_r[j+1];
                                    name_r[j] <= name_r[j+1];
                                    vld_r[j]  <= vld_r[j+1];
                                end else if (KW'(j) < kq_r) begin
                                    vld_r[j] <= 1'b0;
                                end
                            end
                            if (KW'(DEPTH - 1) < kq_r) begin
                                vld_r[DEPTH-1] <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    vld_r <= vld_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k_select_sorter.sv
// Self-checking bench for k_select_sorter: directed jobs plus randomized jobs
// compared against a sorted-queue reference model.
module tb_k_select_sorter;

    localparam int NW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int KW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          start;
    logic [KW-1:0] k;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [NW-1:0] in_name;
    logic [DW-1:0] in_value;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] out_name;
    logic [DW-1:0] out_value;
    logic          out_last;
    logic          busy;
    logic [KW-1:0] count;

    k_select_sorter #(
        .NAME_WIDTH(NW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .k(k),
        .mode(mode),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_last(in_last),
        .in_name(in_name),
        .in_value(in_value),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_name(out_name),
        .out_value(out_value),
        .out_last(out_last),
        .busy(busy),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] name;
        logic [DW-1:0] value;
    } ent_t;

    ent_t mq[$];
    int   kq;
    bit   mmode;
    int   vectors;
    int   miscompares;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_job(input int kin, input bit md);
        start = 1'b1;
        k     = KW'(kin);
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        kq    = (kin == 0) ? 1 : ((kin > DEPTH) ? DEPTH : kin);
        mmode = md;
        mq.delete();
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("in_ready_after_start", 64'(in_ready), 64'd1);
        chk("count_after_start", 64'(count), 64'd0);
    endtask

    task automatic send(input logic [NW-1:0] nm, input logic [DW-1:0] v, input bit last);
        int   p;
        ent_t e;
        chk("in_ready_load", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_name  = nm;
        in_value = v;
        in_last  = last;
        // reference: rank = number of kept entries that beat or tie the newcomer
        p = 0;
        foreach (mq[i]) begin
            if (mmode ? (mq[i].value >= v) : (mq[i].value <= v)) p++;
        end
        if (p < kq) begin
            e.name  = nm;
            e.value = v;
            mq.insert(p, e);
            if (mq.size() > kq) void'(mq.pop_back());
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("count_load", 64'(count), 64'(mq.size()));
        if (last) begin
            chk("in_ready_after_last", 64'(in_ready), 64'd0);
            chk("out_valid_after_last", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic check_entry(input int i, input int n);
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_name", 64'(out_name), 64'(mq[i].name));
        chk("out_value", 64'(out_value), 64'(mq[i].value));
        chk("out_last", 64'(out_last), 64'(i == n - 1));
    endtask

    task automatic drain(input int stall_second, input bit rnd);
        int n;
        int stalls;
        n = mq.size();
        for (int i = 0; i < n; i++) begin
            stalls = (i == 1) ? stall_second : (rnd ? $urandom_range(0, 2) : 0);
            for (int s = 0; s < stalls; s++) begin
                out_ready = 1'b0;
                check_entry(i, n);
                @(negedge clk);
            end
            out_ready = 1'b1;
            check_entry(i, n);
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("out_valid_end", 64'(out_valid), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
        chk("count_end", 64'(count), 64'd0);
        mq.delete();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        k           = '0;
        mode        = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_name     = '0;
        in_value    = '0;
        out_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        chk("reset_out_name", 64'(out_name), 64'd0);
        chk("reset_out_value", 64'(out_value), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // k=3 smallest: expect (1,10),(3,20),(4,30)
        start_job(3, 1'b0);
        send(0, 50, 1'b0);
        send(1, 10, 1'b0);
        send(2, 40, 1'b0);
        send(3, 20, 1'b0);
        send(4, 30, 1'b1);
        chk("t1_first_name", 64'(out_name), 64'd1);
        chk("t1_first_value", 64'(out_value), 64'd10);
        drain(0, 1'b0);

        // k=2 largest with a tie: B before C
        start_job(2, 1'b1);
        send(32'hA, 5, 1'b0);
        send(32'hB, 9, 1'b0);
        send(32'hC, 9, 1'b0);
        send(32'hD, 1, 1'b1);
        chk("t2_tie_name", 64'(out_name), 64'hB);
        drain(0, 1'b0);

        // k larger than the stream
        start_job(8, 1'b0);
        send(0, 7, 1'b0);
        send(1, 3, 1'b0);
        send(2, 5, 1'b1);
        chk("t3_count", 64'(count), 64'd3);
        drain(0, 1'b0);

        // backpressure after first handshake
        start_job(4, 1'b0);
        for (int i = 0; i < 6; i++) send(NW'(i), DW'($urandom_range(0, 99)), i == 5);
        drain(4, 1'b0);

        // k=0 clamps to one entry
        start_job(0, 1'b1);
        send(0, 4, 1'b0);
        send(1, 8, 1'b0);
        send(2, 6, 1'b1);
        chk("t5_k0_last", 64'(out_last), 64'd1);
        drain(0, 1'b0);

        // k above DEPTH clamps; start mid-LOAD ignored
        start_job(DEPTH + 5, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i == 3) begin
                start = 1'b1;
                k     = KW'(1);
                @(negedge clk);
                start = 1'b0;
                chk("mid_start_busy", 64'(busy), 64'd1);
                chk("mid_start_count", 64'(count), 64'd3);
            end
            send(NW'(100 + i), DW'($urandom_range(0, 30)), i == DEPTH + 1);
        end
        chk("t5_clamp_count", 64'(count), 64'(DEPTH));
        drain(0, 1'b1);

        // reset mid-LOAD, then a clean job
        start_job(5, 1'b0);
        send(0, 3, 1'b0);
        send(1, 2, 1'b0);
        send(2, 1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        reset = 1'b0;
        mq.delete();
        @(negedge clk);
        start_job(2, 1'b0);
        send(7, 40, 1'b0);
        send(8, 20, 1'b0);
        send(9, 30, 1'b1);
        drain(0, 1'b0);

        // randomized jobs with ties, bubbles and stalls
        for (int jb = 0; jb < 10; jb++) begin
            start_job($urandom_range(0, DEPTH + 3), 1'($urandom_range(0, 1)));
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send(NW'($urandom), DW'($urandom_range(0, 12)), i == n - 1);
            end
            drain($urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
